// File: rtl/hist_fetch_pkg.sv
// Shared frame geometry, SRAM widths and record types for the colour-history fetch path.
package hist_fetch_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int ADDR_W   = 19;
    localparam int HIST_W   = 4;
    localparam int COORD_W  = 10;
    localparam int CHROMA_W = 8;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [HIST_W-1:0]  history;
    } wb_entry_t;

    typedef struct packed {
        logic [COORD_W-1:0]  x;
        logic [COORD_W-1:0]  y;
        logic [CHROMA_W-1:0] cb;
        logic [CHROMA_W-1:0] cr;
        logic                in_range;
    } side_t;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y);
        return ADDR_W'(32'(y) * 32'(H_ACTIVE) + 32'(x));
    endfunction

    function automatic logic in_frame(input logic [COORD_W-1:0] x,
                                      input logic [COORD_W-1:0] y);
        return (32'(x) < 32'(H_ACTIVE)) && (32'(y) < 32'(V_ACTIVE));
    endfunction

endpackage

// File: rtl/hist_wb_fifo.sv
// Two-entry queue of pending history write-backs {x, y, history}.
module hist_wb_fifo
    import hist_fetch_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output wb_entry_t head,
    output logic      empty,
    output logic      full
);

    logic [1:0] count;
    logic       wr_ptr;
    logic       rd_ptr;
    logic       do_pop;
    wb_entry_t  slots [2];

    assign empty  = (count == 2'd0);
    assign full   = (count == 2'd2);
    assign do_pop = pop & ~empty;
    assign head   = slots[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            count  <= count + {1'b0, push} - {1'b0, do_pop};
            wr_ptr <= wr_ptr ^ push;
            rd_ptr <= rd_ptr ^ do_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            slots[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/hist_fetch.sv
// Pixel stream to SRAM history reads, with queued detector write-backs sharing the one port.
module hist_fetch
    import hist_fetch_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pix_valid,
    output logic                pix_ready,
    input  logic [COORD_W-1:0]  pix_x,
    input  logic [COORD_W-1:0]  pix_y,
    input  logic [CHROMA_W-1:0] pix_Cb,
    input  logic [CHROMA_W-1:0] pix_Cr,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_re,
    output logic                mem_we,
    output logic [HIST_W-1:0]   mem_wdata,
    input  logic [HIST_W-1:0]   mem_rdata,
    input  logic                wb_we,
    input  logic [COORD_W-1:0]  wb_x,
    input  logic [COORD_W-1:0]  wb_y,
    input  logic [HIST_W-1:0]   wb_history,
    output logic                color_valid,
    output logic [HIST_W-1:0]   color_history,
    output logic [COORD_W-1:0]  out_x,
    output logic [COORD_W-1:0]  out_y,
    output logic [CHROMA_W-1:0] out_Cb,
    output logic [CHROMA_W-1:0] out_Cr
);

    // Reset asserts asynchronously and releases on a clock edge; 'run' is a twin
    // of the reset net so the reset tree never feeds datapath logic.
    logic rst_sync_n;
    logic run;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_n <= 1'b0;
            run        <= 1'b0;
        end else begin
            rst_sync_n <= 1'b1;
            run        <= 1'b1;
        end
    end

    logic      fifo_empty;
    logic      fifo_full;
    logic      wb_pop;
    logic      wb_push;
    wb_entry_t wb_head;
    wb_entry_t wb_in;

    assign wb_in   = '{x: wb_x, y: wb_y, history: wb_history};
    assign wb_pop  = ~fifo_empty;
    assign wb_push = wb_we & in_frame(wb_x, wb_y) & (~fifo_full | wb_pop);

    hist_wb_fifo u_wb_fifo (
        .clk       (clk),
        .rst_n     (rst_sync_n),
        .push      (wb_push),
        .push_data (wb_in),
        .pop       (wb_pop),
        .head      (wb_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Pending writes always take the port; pixels are only taken when nothing is queued.
    logic  accept;
    logic  pix_in_range;
    side_t pix_side;

    assign pix_ready    = run & fifo_empty;
    assign accept       = pix_valid & pix_ready;
    assign pix_in_range = in_frame(pix_x, pix_y);
    assign pix_side     = '{x: pix_x, y: pix_y, cb: pix_Cb, cr: pix_Cr, in_range: pix_in_range};

    // Stage p0: SRAM command register
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_re <= accept & pix_in_range;
            mem_we <= wb_pop;
            if (wb_pop) begin
                mem_addr  <= pix_addr(wb_head.x, wb_head.y);
                mem_wdata <= wb_head.history;
            end else if (accept && pix_in_range) begin
                mem_addr <= pix_addr(pix_x, pix_y);
            end
        end
    end

    // Stages p0..pRD_LAT: sideband travels with the read until its data returns
    logic [RD_LAT:0] vld_p;
    side_t           sb_p [RD_LAT+1];

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= accept;
            for (int i = 1; i <= RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        sb_p[0] <= pix_side;
        for (int i = 1; i <= RD_LAT; i++) begin
            sb_p[i] <= sb_p[i-1];
        end
    end

    // Output stage: merge returned history with its sideband
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            color_valid   <= 1'b0;
            color_history <= '0;
            out_x         <= '0;
            out_y         <= '0;
            out_Cb        <= '0;
            out_Cr        <= '0;
        end else begin
            color_valid <= vld_p[RD_LAT];
            if (vld_p[RD_LAT]) begin
                color_history <= sb_p[RD_LAT].in_range ? mem_rdata : '0;
                out_x         <= sb_p[RD_LAT].x;
                out_y         <= sb_p[RD_LAT].y;
                out_Cb        <= sb_p[RD_LAT].cb;
                out_Cr        <= sb_p[RD_LAT].cr;
            end
        end
    end

endmodule

// File: tb/tb_hist_fetch.sv
// Self-checking bench for hist_fetch: SRAM model, detector model and event logs.
`timescale 1ns/1ps
module tb_hist_fetch;

    localparam int RD_LAT = 2;
    localparam int LAT    = RD_LAT + 2;
    localparam int HA     = 640;
    localparam int VA     = 480;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [9:0]  pix_x = '0, pix_y = '0;
    logic [7:0]  pix_Cb = '0, pix_Cr = '0;
    logic [18:0] mem_addr;
    logic        mem_re, mem_we;
    logic [3:0]  mem_wdata;
    logic [3:0]  mem_rdata = '0;
    logic        wb_we = 1'b0;
    logic [9:0]  wb_x = '0, wb_y = '0;
    logic [3:0]  wb_history = '0;
    logic        color_valid;
    logic [3:0]  color_history;
    logic [9:0]  out_x, out_y;
    logic [7:0]  out_Cb, out_Cr;

    always #5 clk = ~clk;

    hist_fetch #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_Cb(pix_Cb), .pix_Cr(pix_Cr),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .wb_we(wb_we), .wb_x(wb_x), .wb_y(wb_y),
        .wb_history(wb_history), .color_valid(color_valid), .color_history(color_history),
        .out_x(out_x), .out_y(out_y), .out_Cb(out_Cb), .out_Cr(out_Cr)
    );

    typedef struct { int cyc; logic [9:0] x; logic [9:0] y; logic [7:0] cb; logic [7:0] cr; logic [3:0] h; } px_rec_t;
    typedef struct { int cyc; logic [18:0] addr; logic [3:0] data; } mem_rec_t;

    px_rec_t  acc_log[$], out_log[$];
    mem_rec_t rd_log[$], wr_log[$];
    logic [3:0] sram [0:(1<<19)-1];
    int         wr_cnt [int];
    int         overlap_cnt = 0;
    logic [3:0] rd_pipe [RD_LAT];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM + observation model, sampled mid-cycle
    always @(negedge clk) begin
        if (pix_valid && pix_ready) acc_log.push_back('{cyc, pix_x, pix_y, pix_Cb, pix_Cr, 4'd0});
        if (color_valid) out_log.push_back('{cyc, out_x, out_y, out_Cb, out_Cr, color_history});
        if (mem_re && mem_we) overlap_cnt++;
        if (mem_re) rd_log.push_back('{cyc, mem_addr, 4'd0});
        if (mem_we) begin
            wr_log.push_back('{cyc, mem_addr, mem_wdata});
            sram[mem_addr] = mem_wdata;
            if (wr_cnt.exists(int'(mem_addr))) wr_cnt[int'(mem_addr)]++;
            else wr_cnt[int'(mem_addr)] = 1;
        end
        mem_rdata = rd_pipe[RD_LAT-1];
        for (int i = RD_LAT-1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
        rd_pipe[0] = mem_re ? sram[mem_addr] : 4'($urandom_range(1, 15));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic idle_inputs();
        pix_valid = 1'b0;
        wb_we     = 1'b0;
    endtask

    task automatic clear_logs();
        acc_log.delete(); out_log.delete(); rd_log.delete(); wr_log.delete();
        overlap_cnt = 0;
    endtask

    task automatic send_pixel(input int x, input int y, input int cb, input int cr);
        bit ok = 1'b0;
        pix_valid = 1'b1;
        pix_x = 10'(x); pix_y = 10'(y); pix_Cb = 8'(cb); pix_Cr = 8'(cr);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = pix_ready;
            step();
        end
        pix_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [76:0] data_out;
        #2 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pix_valid = 1'($urandom); pix_x = 10'($urandom); pix_y = 10'($urandom);
            pix_Cb = 8'($urandom); pix_Cr = 8'($urandom);
            wb_we = 1'($urandom); wb_x = 10'($urandom_range(0, 639));
            wb_y = 10'($urandom_range(0, 479)); wb_history = 4'($urandom);
            @(negedge clk);
            n_cmp++;
            if ({pix_ready, color_valid, mem_re, mem_we} !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_ctrl: got %b expected 0000", {pix_ready, color_valid, mem_re, mem_we});
            end
            data_out = {mem_addr, mem_wdata, color_history, out_x, out_y, out_Cb, out_Cr, 2'b00};
            n_cmp++;
            if (data_out !== '0) begin
                n_bad++;
                $display("FAIL reset_data: got %h expected 0", data_out);
            end
            step();
        end
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (pix_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL release_same_cycle_ready: got %b expected 0", pix_ready);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if (pix_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL release_next_cycle_ready: got %b expected 1", pix_ready);
        end
        step();
    endtask

    task automatic test_single_read();
        clear_logs();
        sram[1283] = 4'b1011;
        send_pixel(3, 2, 'h40, 'h50);
        run_cycles(8);
        n_cmp++;
        if (acc_log.size() != 1 || rd_log.size() != 1 || out_log.size() != 1) begin
            n_bad++;
            $display("FAIL single_counts: got acc=%0d rd=%0d out=%0d expected 1/1/1",
                     acc_log.size(), rd_log.size(), out_log.size());
        end else begin
            n_cmp++;
            if (rd_log[0].addr !== 19'd1283 || rd_log[0].cyc != acc_log[0].cyc + 1) begin
                n_bad++;
                $display("FAIL single_read_cmd: got addr=%0d at +%0d expected 1283 at +1",
                         rd_log[0].addr, rd_log[0].cyc - acc_log[0].cyc);
            end
            n_cmp++;
            if (out_log[0].cyc != acc_log[0].cyc + LAT) begin
                n_bad++;
                $display("FAIL single_latency: got %0d expected %0d", out_log[0].cyc - acc_log[0].cyc, LAT);
            end
            n_cmp++;
            if ({out_log[0].h, out_log[0].x, out_log[0].y, out_log[0].cb, out_log[0].cr} !==
                {4'b1011, 10'd3, 10'd2, 8'h40, 8'h50}) begin
                n_bad++;
                $display("FAIL single_fields: got h=%b x=%0d y=%0d cb=%h cr=%h expected h=1011 x=3 y=2 cb=40 cr=50",
                         out_log[0].h, out_log[0].x, out_log[0].y, out_log[0].cb, out_log[0].cr);
            end
        end
    endtask

    task automatic test_write_priority();
        clear_logs();
        pix_valid = 1'b1; pix_x = 10'd7; pix_y = 10'd3; pix_Cb = 8'h11; pix_Cr = 8'h22;
        wb_we = 1'b1; wb_x = 10'd5; wb_y = 10'd1; wb_history = 4'b0110;
        @(negedge clk);
        n_cmp++;
        if (pix_ready !== 1'b1) begin
            n_bad++; $display("FAIL prio_ready_empty: got %b expected 1", pix_ready);
        end
        step();
        wb_we = 1'b0; pix_x = 10'd9; pix_Cb = 8'h33; pix_Cr = 8'h44;
        @(negedge clk);
        n_cmp++;
        if ({pix_ready, mem_re, mem_we, mem_addr} !== {1'b0, 1'b1, 1'b0, 19'd1927}) begin
            n_bad++;
            $display("FAIL prio_stall: got ready=%b re=%b we=%b addr=%0d expected 0 1 0 1927",
                     pix_ready, mem_re, mem_we, mem_addr);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if ({pix_ready, mem_re, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 1'b1, 19'd645, 4'b0110}) begin
            n_bad++;
            $display("FAIL prio_write: got ready=%b re=%b we=%b addr=%0d wdata=%b expected 1 0 1 645 0110",
                     pix_ready, mem_re, mem_we, mem_addr, mem_wdata);
        end
        step();
        pix_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_re, mem_addr} !== {1'b1, 19'd1929}) begin
            n_bad++;
            $display("FAIL prio_second_read: got re=%b addr=%0d expected 1 1929", mem_re, mem_addr);
        end
        run_cycles(8);
        n_cmp++;
        if (acc_log.size() != 2 || out_log.size() != 2 || wr_log.size() != 1) begin
            n_bad++;
            $display("FAIL prio_counts: got acc=%0d out=%0d wr=%0d expected 2/2/1",
                     acc_log.size(), out_log.size(), wr_log.size());
        end else begin
            n_cmp++;
            if (acc_log[1].cyc - acc_log[0].cyc != 2 || out_log[0].x !== 10'd7 || out_log[1].x !== 10'd9) begin
                n_bad++;
                $display("FAIL prio_order: got gap=%0d x0=%0d x1=%0d expected 2 7 9",
                         acc_log[1].cyc - acc_log[0].cyc, out_log[0].x, out_log[1].x);
            end
        end
    endtask

    task automatic test_range();
        clear_logs();
        send_pixel(640, 0, 'hA1, 'hA2);
        send_pixel(0, 480, 'hB1, 'hB2);
        wb_we = 1'b1; wb_x = 10'd0; wb_y = 10'd480; wb_history = 4'b1111;
        step();
        wb_we = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (pix_ready !== 1'b1) begin
                n_bad++; $display("FAIL range_wb_dropped_ready: got %b expected 1", pix_ready);
            end
            step();
        end
        run_cycles(8);
        n_cmp++;
        if (rd_log.size() != 0 || wr_log.size() != 0) begin
            n_bad++;
            $display("FAIL range_no_mem: got rd=%0d wr=%0d expected 0/0", rd_log.size(), wr_log.size());
        end
        n_cmp++;
        if (acc_log.size() != 2 || out_log.size() != 2) begin
            n_bad++;
            $display("FAIL range_counts: got acc=%0d out=%0d expected 2/2", acc_log.size(), out_log.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (out_log[i].h !== 4'd0 || out_log[i].x !== acc_log[i].x || out_log[i].y !== acc_log[i].y ||
                    out_log[i].cyc != acc_log[i].cyc + LAT) begin
                    n_bad++;
                    $display("FAIL range_out%0d: got h=%b x=%0d y=%0d lat=%0d expected h=0000 x=%0d y=%0d lat=%0d",
                             i, out_log[i].h, out_log[i].x, out_log[i].y, out_log[i].cyc - acc_log[i].cyc,
                             acc_log[i].x, acc_log[i].y, LAT);
                end
            end
        end
    endtask

    task automatic test_closed_loop();
        localparam int N = 100;
        px_rec_t plist[$];
        px_rec_t wbq[$];
        px_rec_t r;
        bit      used [int];
        logic [3:0] wb_exp [int];
        int idx = 0, seen = 0, x, y, a, span;
        clear_logs();
        wr_cnt.delete();
        for (int i = 0; i < N; i++) begin
            do begin
                x = $urandom_range(0, HA-1); y = $urandom_range(0, VA-1); a = y*HA + x;
            end while (used.exists(a));
            used[a] = 1'b1;
            sram[a] = 4'($urandom);
            plist.push_back('{0, 10'(x), 10'(y), 8'($urandom), 8'($urandom), sram[a]});
        end
        for (int t = 0; t < 1000 && (seen < N || wbq.size() > 0); t++) begin
            if (idx < N) begin
                pix_valid = 1'b1; pix_x = plist[idx].x; pix_y = plist[idx].y;
                pix_Cb = plist[idx].cb; pix_Cr = plist[idx].cr;
            end else pix_valid = 1'b0;
            if (wbq.size() > 0) begin
                r = wbq.pop_front();
                wb_we = 1'b1; wb_x = r.x; wb_y = r.y; wb_history = r.h;
            end else wb_we = 1'b0;
            @(negedge clk);
            if (pix_valid && pix_ready) idx++;
            if (color_valid && seen < N) begin
                r = '{0, out_x, out_y, 8'd0, 8'd0, 4'($urandom)};
                wbq.push_back(r);
                wb_exp[int'(plist[seen].y)*HA + int'(plist[seen].x)] = r.h;
                seen++;
            end
            step();
        end
        idle_inputs();
        run_cycles(10);
        n_cmp++;
        if (acc_log.size() != N || out_log.size() != N || wr_log.size() != N) begin
            n_bad++;
            $display("FAIL loop_counts: got acc=%0d out=%0d wr=%0d expected %0d each",
                     acc_log.size(), out_log.size(), wr_log.size(), N);
        end else begin
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if ({out_log[i].x, out_log[i].y, out_log[i].cb, out_log[i].cr, out_log[i].h} !==
                    {plist[i].x, plist[i].y, plist[i].cb, plist[i].cr, plist[i].h} ||
                    out_log[i].cyc != acc_log[i].cyc + LAT) begin
                    n_bad++;
                    $display("FAIL loop_out%0d: got x=%0d y=%0d h=%b lat=%0d expected x=%0d y=%0d h=%b lat=%0d",
                             i, out_log[i].x, out_log[i].y, out_log[i].h, out_log[i].cyc - acc_log[i].cyc,
                             plist[i].x, plist[i].y, plist[i].h, LAT);
                end
            end
            span = acc_log[N-1].cyc - acc_log[0].cyc;
            n_cmp++;
            if (span > 2*(N-1) + 12) begin
                n_bad++;
                $display("FAIL loop_throughput: got %0d cycles for %0d pixels expected at most %0d", span, N, 2*(N-1) + 12);
            end
        end
        for (int i = 0; i < N; i++) begin
            a = int'(plist[i].y)*HA + int'(plist[i].x);
            n_cmp++;
            if (!wr_cnt.exists(a) || wr_cnt[a] != 1 || !wb_exp.exists(a) || sram[a] !== wb_exp[a]) begin
                n_bad++;
                $display("FAIL loop_write%0d: got count=%0d data=%b at addr %0d expected count=1 data=%b",
                         i, wr_cnt.exists(a) ? wr_cnt[a] : 0, sram[a], a, wb_exp.exists(a) ? wb_exp[a] : 4'd0);
            end
        end
        n_cmp++;
        if (overlap_cnt != 0) begin
            n_bad++; $display("FAIL loop_re_we_overlap: got %0d cycles expected 0", overlap_cnt);
        end
    endtask

    task automatic test_reset_midflight();
        clear_logs();
        pix_valid = 1'b1; pix_x = 10'd10; pix_y = 10'd10; pix_Cb = 8'h5A; pix_Cr = 8'hA5;
        wb_we = 1'b1; wb_x = 10'd20; wb_y = 10'd20; wb_history = 4'b1001;
        step();
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({pix_ready, mem_re, mem_we, color_valid} !== 4'b0000) begin
            n_bad++;
            $display("FAIL midflight_in_reset: got %b expected 0000", {pix_ready, mem_re, mem_we, color_valid});
        end
        run_cycles(2);
        reset = 1'b1;
        run_cycles(12);
        n_cmp++;
        if (out_log.size() != 0 || wr_log.size() != 0) begin
            n_bad++;
            $display("FAIL midflight_flushed: got out=%0d wr=%0d expected 0/0", out_log.size(), wr_log.size());
        end
        clear_logs();
        send_pixel(11, 12, 'h01, 'h02);
        run_cycles(8);
        n_cmp++;
        if (out_log.size() != 1) begin
            n_bad++; $display("FAIL midflight_fresh_count: got %0d expected 1", out_log.size());
        end else begin
            n_cmp++;
            if (out_log[0].x !== 10'd11 || out_log[0].y !== 10'd12) begin
                n_bad++;
                $display("FAIL midflight_fresh_pixel: got x=%0d y=%0d expected 11 12", out_log[0].x, out_log[0].y);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_write_priority();
        test_range();
        test_closed_loop();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
